// File: rtl/issue_sched.sv
// Issue scheduler: round-robin picks of operand-ready RS entries for the ALU and the
// address ALU, with memory-path occupancy. Optional counters under ISSUE_STATS_EN.
module issue_sched #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [N_ENTRIES-1:0] entry_valid_i,
  input  logic [N_ENTRIES-1:0] entry_ready_i,
  input  logic [N_ENTRIES-1:0] entry_is_mem_i,
  output logic [IDX_W-1:0]     alu_idx_o,
  output logic [IDX_W-1:0]     mem_idx_o,
  output logic [2:0]           instr_ready_o,
  output logic [N_ENTRIES-1:0] rs_clear_o
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]          stat_alu_issued_o,
  output logic [31:0]          stat_mem_issued_o,
  output logic [31:0]          stat_mem_stall_o
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] BUSY_INIT = CNT_W'(MEM_LAT - 1);

  logic                 aluGnt_q, aluGnt_d;
  logic                 memGnt_q, memGnt_d;
  logic [IDX_W-1:0]     aluIdx_q, aluIdx_d;
  logic [IDX_W-1:0]     memIdx_q, memIdx_d;
  logic [N_ENTRIES-1:0] rsClear_q, rsClear_d;
  logic [IDX_W-1:0]     aluPtr_q, aluPtr_d;
  logic [IDX_W-1:0]     memPtr_q, memPtr_d;
  logic [CNT_W-1:0]     memBusy_q, memBusy_d;

  logic [N_ENTRIES-1:0] elig, aluCand, memCand;
  logic [IDX_W:0]       aluPick, memPick;

  // Rotate the candidate vector so ptr lands at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IDX_W:0] rrPick(input logic [N_ENTRIES-1:0] cand,
                                            input logic [IDX_W-1:0]     ptr);
    logic [2*N_ENTRIES-1:0] dbl;
    logic [IDX_W-1:0]       off;
    logic                   hit;
    dbl = {cand, cand} >> ptr;
    off = '0;
    hit = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        off = IDX_W'(i);
        hit = 1'b1;
      end
    end
    return {hit, ptr + off};
  endfunction

  // The in-flight mask is exactly last cycle's rs_clear, so the clear register doubles as it.
  assign elig    = entry_valid_i & entry_ready_i & ~rsClear_q;
  assign aluCand = elig & ~entry_is_mem_i;
  assign memCand = elig & entry_is_mem_i;
  assign aluPick = rrPick(aluCand, aluPtr_q);
  assign memPick = rrPick(memCand, memPtr_q);

  always_comb begin
    aluGnt_d  = 1'b0;
    memGnt_d  = 1'b0;
    aluIdx_d  = aluIdx_q;
    memIdx_d  = memIdx_q;
    rsClear_d = '0;
    aluPtr_d  = aluPtr_q;
    memPtr_d  = memPtr_q;
    memBusy_d = (memBusy_q != '0) ? memBusy_q - CNT_W'(1) : '0;
    if (flush_i) begin
      aluIdx_d  = '0;
      memIdx_d  = '0;
      memBusy_d = '0;
    end else begin
      if (aluPick[IDX_W]) begin
        aluGnt_d                       = 1'b1;
        aluIdx_d                       = aluPick[IDX_W-1:0];
        aluPtr_d                       = aluPick[IDX_W-1:0] + IDX_W'(1);
        rsClear_d[aluPick[IDX_W-1:0]]  = 1'b1;
      end
      if (memPick[IDX_W] && (memBusy_q == '0)) begin
        memGnt_d                       = 1'b1;
        memIdx_d                       = memPick[IDX_W-1:0];
        memPtr_d                       = memPick[IDX_W-1:0] + IDX_W'(1);
        rsClear_d[memPick[IDX_W-1:0]]  = 1'b1;
        memBusy_d                      = BUSY_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluGnt_q  <= 1'b0;
      memGnt_q  <= 1'b0;
      aluIdx_q  <= '0;
      memIdx_q  <= '0;
      rsClear_q <= '0;
      aluPtr_q  <= '0;
      memPtr_q  <= '0;
      memBusy_q <= '0;
    end else begin
      aluGnt_q  <= aluGnt_d;
      memGnt_q  <= memGnt_d;
      aluIdx_q  <= aluIdx_d;
      memIdx_q  <= memIdx_d;
      rsClear_q <= rsClear_d;
      aluPtr_q  <= aluPtr_d;
      memPtr_q  <= memPtr_d;
      memBusy_q <= memBusy_d;
    end
  end

  assign alu_idx_o     = aluIdx_q;
  assign mem_idx_o     = memIdx_q;
  assign instr_ready_o = {1'b0, memGnt_q, aluGnt_q};
  assign rs_clear_o    = rsClear_q;

`ifdef ISSUE_STATS_EN
  logic [31:0] statAlu_q, statMem_q, statStall_q;
  logic        memStall;

  // A stall is a MEM candidate existing while the memory path is still occupied.
  assign memStall = (|memCand) && (memBusy_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statAlu_q   <= '0;
      statMem_q   <= '0;
      statStall_q <= '0;
    end else begin
      if (aluGnt_q && (statAlu_q != '1))   statAlu_q   <= statAlu_q + 32'd1;
      if (memGnt_q && (statMem_q != '1))   statMem_q   <= statMem_q + 32'd1;
      if (memStall && (statStall_q != '1)) statStall_q <= statStall_q + 32'd1;
    end
  end

  assign stat_alu_issued_o = statAlu_q;
  assign stat_mem_issued_o = statMem_q;
  assign stat_mem_stall_o  = statStall_q;
`endif

endmodule

// File: tb/tb_issue_sched.sv
// Scoreboard bench for issue_sched: a per-cycle reference model pushes expectations,
// a negedge monitor pops and compares; directed scenarios precede a random phase.
module tb_issue_sched;
  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  entryValid = '0, entryReady = '0, entryIsMem = '0;
  logic [IW-1:0] aluIdx, memIdx;
  logic [2:0]    instrReady;
  logic [N-1:0]  rsClear;
`ifdef ISSUE_STATS_EN
  logic [31:0]   statAlu, statMem, statStall;
`endif

  issue_sched #(.N_ENTRIES(N), .IDX_W(IW), .MEM_LAT(LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .entry_valid_i  (entryValid),
    .entry_ready_i  (entryReady),
    .entry_is_mem_i (entryIsMem),
    .alu_idx_o      (aluIdx),
    .mem_idx_o      (memIdx),
    .instr_ready_o  (instrReady),
    .rs_clear_o     (rsClear)
`ifdef ISSUE_STATS_EN
    ,
    .stat_alu_issued_o (statAlu),
    .stat_mem_issued_o (statMem),
    .stat_mem_stall_o  (statStall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    ready;
    logic [IW-1:0] aluIdx;
    logic [IW-1:0] memIdx;
    logic [N-1:0]  clear;
    longint        sAlu, sMem, sStall;
  } expT;

  expT    expQ[$];
  int     testsRun = 0;
  int     testsFailed = 0;
  bit     autoClear = 1'b1;

  int           mAluPtr, mMemPtr, mBusy;
  logic [N-1:0] mLastClear;
  logic [2:0]   mLastReady;
  logic [IW-1:0] mAluIdx, mMemIdx;
  longint       mSAlu, mSMem, mSStall;

  function automatic bit eligible(int k);
    return entryValid[k] && entryReady[k] && !mLastClear[k];
  endfunction

  // Reference model: one expectation per clock, computed from the scheduling rules.
  always @(posedge clk or negedge rst_n) begin : refModel
    expT e;
    int  aluK, memK;
    bit  memAny;
    if (!rst_n) begin
      mAluPtr = 0; mMemPtr = 0; mBusy = 0;
      mLastClear = '0; mLastReady = '0; mAluIdx = '0; mMemIdx = '0;
      mSAlu = 0; mSMem = 0; mSStall = 0;
      expQ.delete();
    end else begin
      aluK = -1; memK = -1; memAny = 1'b0;
      for (int o = 0; o < N; o++) begin
        int k;
        k = (mAluPtr + o) % N;
        if (aluK < 0 && eligible(k) && !entryIsMem[k]) aluK = k;
        k = (mMemPtr + o) % N;
        if (eligible(k) && entryIsMem[k]) begin
          memAny = 1'b1;
          if (memK < 0 && mBusy == 0) memK = k;
        end
      end
      if (mLastReady[0]) mSAlu++;
      if (mLastReady[1]) mSMem++;
      if (memAny && mBusy != 0) mSStall++;
      e.ready = '0;
      e.clear = '0;
      if (flush) begin
        mAluIdx = '0; mMemIdx = '0; mBusy = 0;
      end else begin
        if (mBusy > 0) mBusy--;
        if (aluK >= 0) begin
          e.ready[0] = 1'b1; e.clear[aluK] = 1'b1;
          mAluIdx = IW'(aluK); mAluPtr = (aluK + 1) % N;
        end
        if (memK >= 0) begin
          e.ready[1] = 1'b1; e.clear[memK] = 1'b1;
          mMemIdx = IW'(memK); mMemPtr = (memK + 1) % N; mBusy = LAT - 1;
        end
      end
      e.aluIdx = mAluIdx; e.memIdx = mMemIdx;
      e.sAlu = mSAlu; e.sMem = mSMem; e.sStall = mSStall;
      mLastClear = e.clear;
      mLastReady = e.ready;
      expQ.push_back(e);
    end
  end

  // Monitor: compares the registered outputs against the oldest expectation.
  always @(negedge clk) begin : monitor
    expT e;
    bit  bad;
    if (rst_n && expQ.size() > 0) begin
      e = expQ.pop_front();
      bad = (instrReady !== e.ready) || (aluIdx !== e.aluIdx) ||
            (memIdx !== e.memIdx) || (rsClear !== e.clear);
`ifdef ISSUE_STATS_EN
      bad = bad || (statAlu !== 32'(e.sAlu)) || (statMem !== 32'(e.sMem)) ||
            (statStall !== 32'(e.sStall));
`endif
      testsRun++;
      if (bad) begin
        testsFailed++;
        $display("[TB] FAIL scoreboard @%0t: got ready=%b alu=%0d mem=%0d clear=%b, expected ready=%b alu=%0d mem=%0d clear=%b",
                 $time, instrReady, aluIdx, memIdx, rsClear, e.ready, e.aluIdx, e.memIdx, e.clear);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] r, input logic [N-1:0] m);
    entryValid = v;
    entryReady = r;
    entryIsMem = m;
  endtask

  // Advance one cycle; the RS invalidates entries that were flagged during the finished cycle.
  task automatic stepCycle();
    logic [N-1:0] prev;
    prev = rsClear;
    @(posedge clk);
    #1;
    if (autoClear) entryValid = entryValid & ~prev;
  endtask

  task automatic idle(input int n);
    applyStimulus('0, '0, '0);
    repeat (n) stepCycle();
  endtask

  initial begin : stimulus
    int rrSeq[6];
    int grants7;
    rrSeq = '{1, 3, 6, 1, 3, 6};

    #1;
    checkOutput("reset instr_ready", 32'(instrReady), 32'h0);
    checkOutput("reset rs_clear", 32'(rsClear), 32'h0);
    checkOutput("reset alu_idx", 32'(aluIdx), 32'h0);
    checkOutput("reset mem_idx", 32'(memIdx), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin over held ALU entries 1,3,6
    autoClear = 1'b0;
    applyStimulus(8'b0100_1010, 8'b0100_1010, 8'h00);
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput("rr instr_ready", 32'(instrReady), 32'h1);
      checkOutput("rr alu_idx", 32'(aluIdx), 32'(rrSeq[i]));
      checkOutput("rr rs_clear", 32'(rsClear), 32'(1) << rrSeq[i]);
    end
    autoClear = 1'b1;
    idle(2);

    // Dual issue
    applyStimulus(8'b0010_0100, 8'b0010_0100, 8'b0010_0000);
    stepCycle();
    checkOutput("dual instr_ready", 32'(instrReady), 32'h3);
    checkOutput("dual alu_idx", 32'(aluIdx), 32'd2);
    checkOutput("dual mem_idx", 32'(memIdx), 32'd5);
    checkOutput("dual rs_clear", 32'(rsClear), 32'h24);
    stepCycle();
    idle(2);

    // Memory occupancy with MEM entries 0 and 4
    applyStimulus(8'b0001_0001, 8'b0001_0001, 8'b0001_0001);
    stepCycle();
    checkOutput("occ first grant", 32'(instrReady), 32'h2);
    checkOutput("occ first idx", 32'(memIdx), 32'd0);
    stepCycle();
    checkOutput("occ busy gap", 32'(instrReady), 32'h0);
    stepCycle();
    checkOutput("occ second grant", 32'(instrReady), 32'h2);
    checkOutput("occ second idx", 32'(memIdx), 32'd4);
`ifdef ISSUE_STATS_EN
    checkOutput("occ stat_mem_stall", statStall, 32'd1);
`endif
    idle(3);

    // Asynchronous reset while the memory path is busy
    applyStimulus(8'b0011_0000, 8'b0011_0000, 8'b0001_0000);
    stepCycle();
    checkOutput("pre-reset instr_ready", 32'(instrReady), 32'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset instr_ready", 32'(instrReady), 32'h0);
    checkOutput("async reset rs_clear", 32'(rsClear), 32'h0);
    checkOutput("async reset alu_idx", 32'(aluIdx), 32'h0);
    checkOutput("async reset mem_idx", 32'(memIdx), 32'h0);
    applyStimulus(8'b0100_0010, 8'b0100_0010, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stepCycle();
    checkOutput("post-reset alu_idx", 32'(aluIdx), 32'd1);
    idle(3);

    // Entry 7 stays ready while the RS clear lags one cycle
    applyStimulus(8'h80, 8'h80, 8'h00);
    grants7 = 0;
    repeat (6) begin
      stepCycle();
      if (instrReady[0] && aluIdx == 3'd7) grants7++;
    end
    checkOutput("no double issue", 32'(grants7), 32'd1);
    idle(2);

    // Flush squashes the grant for one cycle
    applyStimulus(8'h08, 8'h08, 8'h00);
    flush = 1'b1;
    stepCycle();
    checkOutput("flush instr_ready", 32'(instrReady), 32'h0);
    checkOutput("flush rs_clear", 32'(rsClear), 32'h0);
    flush = 1'b0;
    stepCycle();
    checkOutput("post-flush instr_ready", 32'(instrReady), 32'h1);
    checkOutput("post-flush alu_idx", 32'(aluIdx), 32'd3);
    idle(3);

    // Random traffic against the scoreboard
    for (int it = 0; it < 600; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!entryValid[i] && ($urandom % 4 == 0)) begin
          entryValid[i] = 1'b1;
          entryIsMem[i] = 1'($urandom % 2);
        end
        entryReady[i] = ($urandom % 3) != 0;
      end
      flush = ($urandom % 20) == 0;
      if (it == 300) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      stepCycle();
    end
    flush = 1'b0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
